// File: rtl/clk_div_pkg.sv
// ============================================================================
// Module      : clk_div_pkg
// Description : Shared state encoding and half-period helper for clk_div_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package clk_div_pkg;

    typedef enum logic [1:0] {
        STOP = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } state_t;

    // Half-period in reference cycles for a requested output frequency.
    function automatic int unsigned half_calc(input int unsigned freq, input int unsigned ref_clk);
        return ref_clk / (2 * freq);
    endfunction

endpackage

`default_nettype wire

// File: rtl/clk_div_core.sv
// ============================================================================
// Module      : clk_div_core
// Description : Divide counter, clk_out toggle flop and tick/fall generation.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module clk_div_core #(
    parameter int unsigned NBITS = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             run,
    input  logic [NBITS-1:0] half,
    output logic             clk_out,
    output logic             tick,
    output logic             fall
);

    localparam logic [NBITS-1:0] c_ONE = NBITS'(1);

    logic [NBITS-1:0] r_cnt;
    logic             r_clk_out;
    logic             r_tick;
    logic             w_wrap;

    assign w_wrap  = run && (r_cnt == (half - c_ONE));
    // Boundary strobe: this edge's toggle takes clk_out from 1 to 0.
    assign fall    = w_wrap && r_clk_out;
    assign clk_out = r_clk_out;
    assign tick    = r_tick;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_cnt     <= '0;
            r_clk_out <= 1'b0;
            r_tick    <= 1'b0;
        end else if (run) begin
            if (w_wrap) begin
                r_cnt     <= '0;
                r_clk_out <= ~r_clk_out;
                r_tick    <= 1'b1;
            end else begin
                r_cnt     <= r_cnt + c_ONE;
                r_tick    <= 1'b0;
            end
        end else begin
            r_tick <= 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: rtl/clk_div_ctrl.sv
// ============================================================================
// Module      : clk_div_ctrl
// Description : Glitch-free programmable clock divider with reload handshake.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module clk_div_ctrl
    import clk_div_pkg::*;
#(
    parameter int unsigned      NBITS           = 32,
    parameter int unsigned      REFERENCE_CLOCK = 50_000_000,
    parameter int unsigned      FREQUENCY       = 150_000,
    parameter logic [NBITS-1:0] DEFAULT_HALF    = NBITS'(half_calc(FREQUENCY, REFERENCE_CLOCK))
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             enable,
    input  logic             cfg_valid,
    input  logic [NBITS-1:0] cfg_half,
    output logic             cfg_ready,
    output logic             cfg_done,
    output logic             cfg_err,
    output logic [NBITS-1:0] active_half,
    output logic             clk_out,
    output logic             tick,
    output logic             running
);

    state_t           r_state;
    state_t           w_state_n;
    logic [NBITS-1:0] r_active_half;
    logic [NBITS-1:0] w_half_n;
    logic [NBITS-1:0] r_shadow;
    logic [NBITS-1:0] w_shadow_n;
    logic             r_done;
    logic             w_done_n;
    logic             r_err;
    logic             w_err_n;
    logic             w_clear;
    logic             w_run;
    logic             w_fall;
    logic             w_clk_out;
    logic             w_hs;
    logic             w_zero;
    logic             w_accept;

    assign cfg_ready   = (r_state != PEND);
    assign cfg_done    = r_done;
    assign cfg_err     = r_err;
    assign active_half = r_active_half;
    assign running     = (r_state != STOP);
    assign clk_out     = w_clk_out;

    assign w_hs     = cfg_valid && cfg_ready;
    assign w_zero   = (cfg_half == '0);
    assign w_accept = w_hs && !w_zero;
    assign w_run    = (r_state != STOP);

    clk_div_core #(
        .NBITS (NBITS)
    ) u_core (
        .clk     (clk_in),
        .rst     (reset),
        .clear   (w_clear),
        .run     (w_run),
        .half    (r_active_half),
        .clk_out (w_clk_out),
        .tick    (tick),
        .fall    (w_fall)
    );

    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_state       <= STOP;
            r_active_half <= DEFAULT_HALF;
            r_shadow      <= '0;
            r_done        <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            r_state       <= w_state_n;
            r_active_half <= w_half_n;
            r_shadow      <= w_shadow_n;
            r_done        <= w_done_n;
            r_err         <= w_err_n;
        end
    end

    always_comb begin
        w_state_n  = r_state;
        w_half_n   = r_active_half;
        w_shadow_n = r_shadow;
        w_done_n   = 1'b0;
        w_err_n    = w_hs && w_zero;
        w_clear    = 1'b0;
        case (r_state)
            STOP: begin
                w_clear = 1'b1;
                if (w_accept) begin
                    w_half_n = cfg_half;
                    w_done_n = 1'b1;
                end
                if (enable) begin
                    w_state_n = RUN;
                end
            end
            RUN: begin
                // A new value is never dropped; a stop request is then honoured at the reload boundary.
                if (w_accept) begin
                    w_shadow_n = cfg_half;
                    w_state_n  = PEND;
                end else if (!enable) begin
                    if (!w_clk_out) begin
                        w_state_n = STOP;
                        w_clear   = 1'b1;
                    end else if (w_fall) begin
                        w_state_n = STOP;
                    end
                end
            end
            PEND: begin
                if (w_fall) begin
                    w_half_n  = r_shadow;
                    w_done_n  = 1'b1;
                    w_state_n = enable ? RUN : STOP;
                end
            end
            default: begin
                w_state_n = STOP;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: doc/clk_div_ctrl.md
# clk_div_ctrl

Runtime-programmable, glitch-free clock-divider controller. It owns the divide counter and the `clk_out` toggle flop, and accepts new half-period values over a valid/ready handshake. New values take effect only on a full-period boundary (the falling edge of `clk_out`), and the output is started and stopped cleanly. It sits between the register/config logic and any peripheral that needs a slow, retunable clock (serial bit clocks, sample strobes).

## Interface
- `NBITS`, 32: width of the counter, shadow register and half-period registers.
- `REFERENCE_CLOCK`, 50_000_000: `clk_in` frequency in Hz.
- `FREQUENCY`, 150_000: default output frequency in Hz.
- `DEFAULT_HALF`, REFERENCE_CLOCK/(2*FREQUENCY) = 166: half-period loaded at reset, in `clk_in` cycles.

Ports:
- `clk_in` in 1: the single clock; every flop is on its rising edge.
- `reset` in 1: synchronous reset, active high.
- `enable` in 1: level; 1 runs the divider, 0 requests a clean stop.
- `cfg_valid` in 1: a new half-period is offered.
- `cfg_half` in NBITS: the offered half-period, in `clk_in` cycles.
- `cfg_ready` out 1: the controller can accept a value.
- `cfg_done` out 1: one-cycle pulse when an accepted value is applied.
- `cfg_err` out 1: one-cycle pulse when an offered value of 0 is rejected.
- `active_half` out NBITS: the half-period currently in use.
- `clk_out` out 1: the divided clock, registered.
- `tick` out 1: one-cycle pulse in every cycle where `clk_out` has just changed value.
- `running` out 1: high when the state is not STOP.

## Operation
- The FSM has three states: STOP, RUN and PEND (a reload is waiting).
- Reset values:
  - state STOP, counter 0, `clk_out` 0.
  - `active_half` = DEFAULT_HALF, shadow 0.
  - `cfg_ready` 1; `cfg_done`, `cfg_err`, `tick` and `running` 0.
- STOP:
  - counter is held at 0 and `clk_out` at 0.
  - If `enable`=1, the next state is RUN.
- RUN and PEND counting:
  - The counter increments each cycle.
  - When counter == `active_half`-1, the counter goes to 0, `clk_out` toggles and `tick` pulses.
- `cfg_ready` = (state != PEND).
- A handshake fires when `cfg_valid` && `cfg_ready`:
  - If `cfg_half`==0: pulse `cfg_err`. Nothing else changes.
  - In STOP: `active_half` is loaded on the next edge and `cfg_done` pulses.
  - In RUN: store the value in the shadow register and go to PEND.
- Applying a reload from PEND:
  - The boundary is the cycle where the toggle takes `clk_out` from 1 to 0.
  - At the boundary: `active_half` takes the shadow value, the counter goes to 0 and `cfg_done` pulses.
  - Next state is RUN if `enable`=1, otherwise STOP.
- Stopping:
  - In RUN with `enable`=0 and `clk_out`=0: go to STOP immediately and clear the counter. No runt high pulse is produced.
  - In RUN with `enable`=0 and `clk_out`=1: keep counting and go to STOP at the 1→0 toggle.
- `enable` returning to 1 before the stop boundary cancels the stop; counting continues uninterrupted.
- A handshake in the same cycle as a boundary in RUN goes to PEND. That value is applied at the next boundary, not the current one.
- `active_half`=1 gives `clk_out` = `clk_in`/2, with `tick` high every cycle.
- Counter arithmetic is unsigned NBITS. The comparison is against `active_half`-1, which never wraps because 0 is rejected.

## Timing
- Enable sampled high in STOP at edge t: state is RUN after t. The first rise of `clk_out` is visible `active_half` cycles later.
- Output period = 2*`active_half` cycles, duty cycle exactly 50%.
- `tick` and the new `clk_out` value appear in the same cycle. Both are registered, so there is zero combinational path from the inputs.
- Reload latency in RUN: from acceptance to at most one full period plus the remaining high phase. It is always applied at a falling edge, and the new period starts with a full low phase.
- `cfg_done` is coincident with the first cycle of the new `active_half`.
- `reset` has priority over everything, including mid-period and PEND. A pending shadow value is discarded and no `cfg_done` is issued.

## Structure
- Package `clk_div_pkg` contains:
  - the state enum (STOP, RUN, PEND);
  - the function `half_calc(freq, ref)` = ref/(2*freq), used to derive DEFAULT_HALF.
- Sub-module `clk_div_core` contains the counter, the toggle flop and `tick` generation.
  - Inputs: `clear`, `run`, `half`.
  - Outputs: `clk_out`, `tick`, `fall` (the 1→0 boundary strobe).
- `clk_div_ctrl` contains the FSM, the shadow register and the handshake.

## Test plan
- Reset, then `enable`=1 with default 166: `clk_out` rises 166 cycles after RUN, period 332, `tick` at every edge, `cfg_ready`=1.
- In STOP, offer `cfg_half`=5: accepted in 1 cycle, `cfg_done` pulses, `active_half`=5. After enable, period is 10.
- Running at 10, offer 3 midway through the high phase: `cfg_ready` drops, the old period completes, then `cfg_done` at the falling edge, followed by low 3 / high 3.
- Offer `cfg_half`=0 in any state: `cfg_err` for one cycle, `active_half` and state unchanged.
- Drop `enable` during a high phase with half=4: high phase completes to 4 cycles, then STOP with `clk_out`=0 and no short pulse. Drop `enable` during a low phase: immediate STOP.
- Assert `reset` while in PEND: next cycle shows STOP, `active_half`=166, `clk_out`=0, no `cfg_done`. With half=1, `clk_out` toggles every cycle.
